// File: rtl/pla_sweep_pkg.sv
// Shared types and widths for the PLA sweeper: FSM state encoding and the
// fixed PLA pin counts of the C64 part.
package pla_sweep_pkg;

  localparam int PLA_IN_W     = 16;
  localparam int PLA_OUT_W    = 8;
  localparam int GLITCH_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE_A,
    SAMPLE_B,
    EMIT,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/pla_sweeper_sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLA outputs. The data path is
// deliberately reset-free; the sweeper never samples it until well after reset.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    meta_reg <= d;
    q_reg    <= meta_reg;
  end

  assign q = q_reg;

endmodule

// File: rtl/pla_sweeper.sv
// Drives the PLA inputs through an inclusive address range, double-samples
// the settled outputs and streams (address, data, glitch) over valid/ready.
module pla_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int ADDR_W        = PLA_IN_W,
  parameter int DATA_W        = PLA_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W-1:0]       end_addr,
  output logic [ADDR_W-1:0]       pla_i,
  input  logic [DATA_W-1:0]       pla_f,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ADDR_W-1:0]       res_addr,
  output logic [DATA_W-1:0]       res_data,
  output logic                    res_glitch,
  output logic                    busy,
  output logic                    done,
  output logic [GLITCH_CNT_W-1:0] glitch_count
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = '1;

  sweep_state_t              state_reg;
  logic [ADDR_W-1:0]         cur_reg;
  logic [ADDR_W-1:0]         end_reg;
  logic [ADDR_W-1:0]         pla_i_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [DATA_W-1:0]         s1_reg;
  logic [DATA_W-1:0]         s2_reg;
  logic                      res_valid_reg;
  logic                      res_glitch_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [GLITCH_CNT_W-1:0]   glitch_count_reg;
  logic [DATA_W-1:0]         sync_f;
  logic [ADDR_W-1:0]         cur_next;
  logic                      differ;

  sync_2ff #(
    .WIDTH (DATA_W)
  ) u_sync (
    .clk (clk),
    .d   (pla_f),
    .q   (sync_f)
  );

  assign cur_next = cur_reg + ADDR_W'(1);
  assign differ   = (s1_reg != sync_f);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cur_reg          <= '0;
      end_reg          <= '0;
      pla_i_reg        <= '0;
      cnt_reg          <= '0;
      s1_reg           <= '0;
      s2_reg           <= '0;
      res_valid_reg    <= 1'b0;
      res_glitch_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      glitch_count_reg <= '0;
    end else if (state_reg != IDLE && abort) begin
      // Abort drops any pending result as consumed; drive and count are kept.
      state_reg     <= IDLE;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cur_reg          <= start_addr;
            end_reg          <= end_addr;
            pla_i_reg        <= start_addr;
            cnt_reg          <= SETTLE_LOAD;
            glitch_count_reg <= '0;
            busy_reg         <= 1'b1;
            state_reg        <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg <= SAMPLE_A;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        SAMPLE_A: begin
          s1_reg    <= sync_f;
          state_reg <= SAMPLE_B;
        end
        SAMPLE_B: begin
          s2_reg         <= sync_f;
          res_glitch_reg <= differ;
          res_valid_reg  <= 1'b1;
          if (differ && glitch_count_reg != GLITCH_MAX) begin
            glitch_count_reg <= glitch_count_reg + GLITCH_CNT_W'(1);
          end
          state_reg <= EMIT;
        end
        EMIT: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            // Termination compares cur itself, so a full 0..FFFF sweep ends cleanly.
            if (cur_reg == end_reg) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              cur_reg   <= cur_next;
              pla_i_reg <= cur_next;
              cnt_reg   <= SETTLE_LOAD;
              state_reg <= SETTLE;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign pla_i        = pla_i_reg;
  assign res_valid    = res_valid_reg;
  assign res_addr     = cur_reg;
  assign res_data     = s2_reg;
  assign res_glitch   = res_glitch_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign glitch_count = glitch_count_reg;

endmodule

// File: doc/pla_sweeper.md
Name: pla_sweeper

Overview:
Bench-side initiator for the C64 PLA replacement. It drives the 16 PLA inputs (i0..i15) through a programmable address range and waits a settle interval. It then double-samples the 8 PLA outputs (f0..f7) and streams each (address, data, glitch) result over a valid/ready interface to the capture/UART logic. It lives in the FPGA test rig that characterises the dodgy PLA and the original part.

Parameters:
SETTLE_CYCLES, 8, cycles held in SETTLE after a new vector is driven; must be >= 3; covers PLA propagation plus the 2 synchroniser flops.
ADDR_W, 16, PLA input width.
DATA_W, 8, PLA output width.

Ports:
clk  in  1  rig clock
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a sweep; accepted only in IDLE
abort  in  1  stops the sweep from any state
start_addr  in  ADDR_W  first vector, latched on start
end_addr  in  ADDR_W  last vector, inclusive, latched on start
pla_i  out  ADDR_W  registered drive to PLA inputs i0..i15 (bit n = in)
pla_f  in  DATA_W  asynchronous PLA outputs f0..f7 (bit n = fn)
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_addr  out  ADDR_W  vector the result belongs to
res_data  out  DATA_W  second sample of pla_f
res_glitch  out  1  first and second samples differed
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result is accepted
glitch_count  out  16  saturating count of glitching vectors in the current sweep

Behaviour:
- Reset (rst_n low at a clk edge) returns the block to IDLE. All outputs go to 0: pla_i, res_*, busy, done, glitch_count. Reset overrides start and abort.
- pla_f passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- States: IDLE, SETTLE, SAMPLE_A, SAMPLE_B, EMIT, DONE.
- IDLE: start=1 triggers these actions on the same edge:
  - latch start_addr and end_addr;
  - set cur=start_addr and pla_i<=start_addr;
  - set cnt<=SETTLE_CYCLES-1 and clear glitch_count;
  - move to SETTLE.
  start is ignored in every other state.
- SETTLE: decrement cnt; at cnt==0 move to SAMPLE_A. The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE_A: s1<=sync(pla_f); move to SAMPLE_B.
- SAMPLE_B: s2<=sync(pla_f); move to EMIT.
- EMIT:
  - res_valid=1, res_addr=cur, res_data=s2, res_glitch=(s1!=s2).
  - res_* stays stable while res_valid=1 and res_ready=0.
  - glitch_count increments by 1, saturating at 0xFFFF, on entry to EMIT when s1!=s2.
- Handshake (res_valid & res_ready):
  - if cur==end_addr, go to DONE;
  - otherwise cur<=cur+1 mod 2^ADDR_W, pla_i<=cur+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - res_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE. pla_i holds the last vector.
- Latency:
  - start at cycle 0 → pla_i valid at cycle 1 → first res_valid at cycle SETTLE_CYCLES+3.
  - Handshake at cycle t → next res_valid at t+SETTLE_CYCLES+3.
  - Default timing: 11 cycles per vector with res_ready held high.
- Range rules:
  - start_addr==end_addr produces exactly one result.
  - end_addr<start_addr wraps 0xFFFF→0x0000 and continues to end_addr.
  - start=0x0000 with end=0xFFFF sweeps all 65536 vectors; the loop terminates because the comparison is on cur, not on overflow.
- abort=1 in any non-IDLE state:
  - next state is IDLE and res_valid clears on the next edge;
  - done is not pulsed;
  - pla_i and glitch_count keep their values.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- Simultaneous abort and handshake: abort wins; the result counts as consumed, but no advance and no done.

Decomposition:
- Package pla_sweep_pkg holds:
  - state enum sweep_state_t (IDLE, SETTLE, SAMPLE_A, SAMPLE_B, EMIT, DONE);
  - constants PLA_IN_W=16, PLA_OUT_W=8, GLITCH_CNT_W=16.
- One sub-module, sync_2ff, is a parameterised-width 2-flop synchroniser for pla_f. It has no reset on its data path. Everything else stays in pla_sweeper.

Test Plan:
- Single vector: model PLA drives f = i[7:0]^0x5A; start with start=end=0x1234, res_ready=1 → res_valid at cycle 11 with res_addr=0x1234, res_data=0x6E, res_glitch=0; done at cycle 12; busy low from cycle 13.
- Back-pressure: sweep 0x0000..0x0003 with res_ready low for 20 cycles on each result → 4 results in order, res_* stable while stalled, exactly one done.
- Wrap: start=0xFFFE, end=0x0001 → res_addr sequence FFFE, FFFF, 0000, 0001; done after 0x0001.
- Glitch: model toggles f0 between the SAMPLE_A and SAMPLE_B cycles for address 0x0002 only, over sweep 0..3 → res_glitch=1 only for 0x0002; glitch_count=1 at done.
- Abort mid-sweep: start range 0..0xFFFF, assert abort in SETTLE of the third vector → IDLE next cycle, no done, busy=0, pla_i=0x0002; a new start is then accepted normally.
- Reset mid-EMIT: drop rst_n while res_valid=1 → the next edge shows all outputs at 0 and state IDLE; start is ignored while rst_n is low.
